// File: rtl/invaders_pkg.sv
// Shared constants and types for the invaders game blocks: HID keycodes,
// screen geometry and the missile state encoding.
package invaders_pkg;

  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [0:0] {
    MS_IDLE   = 1'b0,
    MS_FLYING = 1'b1
  } missile_state_t;

endpackage

// File: rtl/frame_tick.sv
// One-clock pulse on each rising edge of a level that is already synchronous
// to clk (e.g. VGA vsync); shared by every per-frame block.
module frame_tick (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic tick
);

  logic level_q;

  // Delayed copy of the level for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  assign tick = level & ~level_q;

endmodule

// File: rtl/player_controller.sv
// Player ship movement (A/D keys, clamped) and single-missile launch/flight.
// The missile is built only when PLAYER_MISSILE_EN is defined; otherwise its outputs are 0.
module player_controller
  import invaders_pkg::*;
#(
  parameter int PLAYER_Y     = 440,
  parameter int X_MIN        = 13,
  parameter int X_MAX        = 626,
  parameter int STEP         = 2,
  parameter int MISSILE_STEP = 6
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       hit,
  output logic [9:0] PlayerX,
  output logic [9:0] PlayerY,
  output logic [9:0] MissileX,
  output logic [9:0] MissileY,
  output logic       missile_active
);

  logic        tick;
  logic [10:0] x_wide;
  logic [10:0] x_left;
  logic [10:0] x_right;
  logic [9:0]  x_next;

  frame_tick u_frame_tick (
    .clk   (Clk),
    .rst   (Reset),
    .level (frame_clk),
    .tick  (tick)
  );

  // Clamp in 11 bits: a borrow shows up in bit 10 instead of wrapping.
  always_comb begin
    x_wide  = {1'b0, PlayerX};
    x_left  = x_wide - 11'(STEP);
    x_right = x_wide + 11'(STEP);
    if (keycode == KEY_A) begin
      x_next = (x_left[10] || (x_left < 11'(X_MIN))) ? 10'(X_MIN) : x_left[9:0];
    end else if (keycode == KEY_D) begin
      x_next = (x_right > 11'(X_MAX)) ? 10'(X_MAX) : x_right[9:0];
    end else begin
      x_next = PlayerX;
    end
  end

  // Player position register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      PlayerX <= 10'd320;
      PlayerY <= 10'(PLAYER_Y);
    end else begin
      PlayerY <= 10'(PLAYER_Y);
      if (tick) begin
        PlayerX <= x_next;
      end
    end
  end

`ifdef PLAYER_MISSILE_EN
  missile_state_t state;
  missile_state_t state_next;
  logic [9:0]     mx_next;
  logic [9:0]     my_next;
  logic           fire_armed;
  logic           armed_next;

  // Missile next state; launch uses the pre-move PlayerX.
  always_comb begin
    state_next = state;
    mx_next    = MissileX;
    my_next    = MissileY;
    armed_next = fire_armed;
    if (tick) begin
      case (state)
        MS_IDLE: begin
          if ((keycode == KEY_SPACE) && fire_armed) begin
            state_next = MS_FLYING;
            mx_next    = PlayerX;
            my_next    = 10'(PLAYER_Y - 8);
          end else begin
            state_next = MS_IDLE;
          end
        end
        MS_FLYING: begin
          if (hit || (MissileY < 10'(MISSILE_STEP))) begin
            state_next = MS_IDLE;
          end else begin
            my_next = MissileY - 10'(MISSILE_STEP);
          end
        end
        default: begin
          state_next = MS_IDLE;
        end
      endcase
      // Space seen while idle either fires or was already disarmed.
      if (keycode != KEY_SPACE) begin
        armed_next = 1'b1;
      end else if (state == MS_IDLE) begin
        armed_next = 1'b0;
      end else begin
        armed_next = fire_armed;
      end
    end else begin
      armed_next = fire_armed;
    end
  end

  // Missile state and registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state          <= MS_IDLE;
      MissileX       <= 10'd0;
      MissileY       <= 10'd0;
      fire_armed     <= 1'b1;
      missile_active <= 1'b0;
    end else begin
      state          <= state_next;
      MissileX       <= mx_next;
      MissileY       <= my_next;
      fire_armed     <= armed_next;
      missile_active <= (state_next == MS_FLYING);
    end
  end
`else
  logic unused_hit;

  assign unused_hit     = hit;
  assign MissileX       = 10'd0;
  assign MissileY       = 10'd0;
  assign missile_active = 1'b0;
`endif

endmodule

// File: doc/player_controller.md
PLAYER_CONTROLLER -- requirements
Module: player_controller

Interface
REQ-001 Parameter PLAYER_Y, default 440: fixed player centre row, in pixels.
REQ-002 Parameter X_MIN, default 13: leftmost allowed player centre column.
REQ-003 Parameter X_MAX, default 626: rightmost allowed player centre column.
REQ-004 Parameter STEP, default 2: player horizontal move per frame, in pixels.
REQ-005 Parameter MISSILE_STEP, default 6: missile upward move per frame, in pixels.
REQ-006 Port Clk, input, 1: the single clock.
REQ-007 Port Reset, input, 1: asynchronous, active-high reset.
REQ-008 Port frame_clk, input, 1: VGA vsync level, synchronous to Clk.
REQ-009 Port keycode, input, 8: current USB HID keycode; 0x00 means no key.
REQ-010 Port hit, input, 1: missile collided this frame; level sampled on frame tick.
REQ-011 Port PlayerX, output, 10: player centre column, fed to color_mapper Player.
REQ-012 Port PlayerY, output, 10: player centre row, constant PLAYER_Y.
REQ-013 Port MissileX, output, 10: missile column.
REQ-014 Port MissileY, output, 10: missile row.
REQ-015 Port missile_active, output, 1: the missile is to be drawn.

Function
REQ-016 Frame tick SHALL be one Clk cycle wide, on the rising edge of frame_clk (registered copy, tick = frame_clk & ~frame_clk_q); all state updates occur only on tick.
REQ-017 On tick, keycode 0x04 (A) SHALL set PlayerX = max(PlayerX-STEP, X_MIN); 0x07 (D) SHALL set min(PlayerX+STEP, X_MAX); other codes leave PlayerX unchanged.
REQ-018 Clamp arithmetic SHALL be done at 11 bits so that underflow or overflow never wraps.
REQ-019 Missile FSM states: IDLE and FLYING.
REQ-020 IDLE->FLYING on tick when keycode==0x2C (space) and fire_armed=1: MissileX=PlayerX (pre-move value), MissileY=PLAYER_Y-8, fire_armed cleared.
REQ-021 fire_armed SHALL set on any tick with keycode!=0x2C; holding space therefore fires exactly once per press.
REQ-022 FLYING on tick: if hit=1 or MissileY<MISSILE_STEP -> IDLE; else MissileY -= MISSILE_STEP; MissileX constant.
REQ-023 hit and top-exit on the same tick SHALL give a single transition to IDLE; hit in IDLE is ignored; space in FLYING is ignored.
REQ-024 missile_active SHALL equal (state==FLYING), registered; outputs change one Clk after the tick.

Reset
REQ-025 Reset SHALL asynchronously force PlayerX=320, PlayerY=PLAYER_Y, MissileX=0, MissileY=0, state=IDLE, missile_active=0, fire_armed=1, frame_clk_q=0.
REQ-026 Reset asserted mid-flight SHALL drop missile_active on the same edge, with no further tick processing until Reset is released.

Configuration
REQ-027 Macro PLAYER_MISSILE_EN defined: REQ-019..REQ-024 are implemented.
REQ-028 PLAYER_MISSILE_EN undefined: no FSM logic; MissileX, MissileY and missile_active are tied to 0; hit and space are ignored.

Structure
REQ-029 Package invaders_pkg SHALL hold the keycode constants (KEY_A, KEY_D, KEY_SPACE), SCREEN_W=640, SCREEN_H=480 and the missile state enum.
REQ-030 A sub-module frame_tick SHALL implement REQ-016 and be reused by other per-frame blocks.

Verification
REQ-031 Reset, then keycode 0x07 held for 10 ticks -> PlayerX=340; no change between ticks.
REQ-032 PlayerX=14, keycode 0x04 for 3 ticks -> PlayerX=13, 13, 13 (no wrap).
REQ-033 PlayerX=200, space held 20 ticks -> one launch at MissileX=200, MissileY=432; MissileY falls 6 per tick; space held stays ignored.
REQ-034 In flight at MissileY=4 with hit=1 on the same tick -> IDLE, missile_active=0 after one Clk.
REQ-035 Reset pulsed mid-flight between ticks -> missile_active=0 immediately and PlayerX=320.
REQ-036 Build without PLAYER_MISSILE_EN, press space -> missile outputs remain 0; movement still passes REQ-031.
